fifo_rd_drain: RTL
==================

// Module: fifo_rd_drain
// PURPOSE
//   Read-side consumer of the async FIFO, in the FIFO read clock domain. Watches the
//   FIFO empty flag and pops words with a single-cycle rinc pulse. Holds each word in an
//   output register and delivers it over a valid/ready handshake to the downstream
//   serializer (UART TX path). Pop rate is limited so the registered empty flag is never
//   read stale.
// PARAMETERS
//   DATA_WIDTH   8   width of FIFO read data and of out_data
// PORTS
//   CLK        in   1           FIFO read-domain clock, rising edge
//   RST        in   1           synchronous reset, active-high
//   empty      in   1           FIFO empty flag (registered in the FIFO read logic)
//   rdata      in   DATA_WIDTH  FIFO read data at the current raddr (combinational)
//   rinc       out  1           pop strobe to the FIFO read logic, one cycle per word
//   out_data   out  DATA_WIDTH  word presented downstream
//   out_valid  out  1           out_data holds an undelivered word
//   out_ready  in   1           downstream accepts out_data this cycle
// BEHAVIOUR
//   - Clock and reset: one clock (CLK). RST is synchronous and active-high.
//     The FIFO read logic is reset in the same cycle.
//   - Reset values: state=IDLE, out_valid=0, out_data=0, rinc=0.
//     rinc is forced to 0 while RST=1.
//   - FSM states: IDLE, SETTLE.
//   - Pop condition: pop = (state==IDLE) & !empty & (!out_valid | out_ready).
//     pop is combinational from registered state and inputs.
//   - When pop=1:
//       rinc=1 in the same cycle.
//       At the next edge: out_data<=rdata, out_valid<=1, state<=SETTLE.
//   - SETTLE lasts exactly 1 cycle. rinc=0 throughout, then state returns to IDLE.
//     Reason: the FIFO updates empty one edge after rptr moves, so no back-to-back pops.
//   - Handshake: a transfer happens on an edge where out_valid & out_ready.
//       Transfer without pop: out_valid<=0, out_data holds its value.
//       Transfer and pop together: out_valid stays 1 and out_data loads the new rdata.
//         This gives no bubble on the output side.
//   - out_valid=1 & out_ready=0: out_data and out_valid stay stable. No pop.
//   - Throughput: at most 1 word per 2 cycles.
//     First word: out_valid rises 1 cycle after empty falls (while in IDLE).
//   - Empty during SETTLE is ignored. In IDLE, empty=1 blocks popping.
//     out_valid still drains normally.
//   - Reset mid-operation: any word held in out_data is dropped. The FSM returns to IDLE.
//     The FIFO is reset in the same cycle, so its pointers stay consistent.
// CONFIGURATION
//   FIFO_DRAIN_CNT_EN defined:
//     Adds output port drain_cnt (16 bits).
//     drain_cnt increments once per completed out_valid & out_ready transfer and wraps
//     0xFFFF->0x0000. Reset value is 0.
//   FIFO_DRAIN_CNT_EN undefined:
//     No drain_cnt port and no counter logic. All other behaviour is identical.
// STRUCTURE
//   Package fifo_drain_pkg:
//     state enum {IDLE, SETTLE}
//     DRAIN_CNT_WIDTH = 16
//     default DATA_WIDTH constant
//   Sub-modules: none. FSM, output register and optional counter stay inline.
// TESTING
//   1. RST=1 for 3 cycles with empty=0 -> rinc=0 every cycle; after release,
//      out_valid=0 and out_data=0.
//   2. Single word: empty 1->0 with rdata=0xA5, out_ready=0 -> rinc high exactly 1 cycle;
//      next cycle out_valid=1, out_data=0xA5; it holds for 10 cycles with no further rinc.
//   3. Streaming: 4 words 0x01..0x04 queued, out_ready=1 -> rinc pulses on alternate
//      cycles; out_data sequence is 0x01,0x02,0x03,0x04 with no duplicates or drops.
//   4. Backpressure: out_ready toggles 1,0,0,1 while words are pending -> no pop while
//      out_valid=1 & out_ready=0; each word is seen exactly once at the output.
//   5. Empty returns: empty rises during SETTLE after the last word -> no extra rinc;
//      out_valid clears after the final handshake.
//   6. Reset mid-stream: RST=1 while out_valid=1 holding 0x3C -> next cycle out_valid=0,
//      state=IDLE; with FIFO_DRAIN_CNT_EN defined, drain_cnt=0 and it counts 3 after
//      3 transfers.

Source files
------------

// File: rtl/fifo_rd_drain_pkg.sv
// fifo_drain_pkg: shared types and constants for the async-FIFO read-side drain.
//   state_e             drain FSM state encoding
//   DRAIN_CNT_WIDTH     width of the optional transfer counter
//   DEFAULT_DATA_WIDTH  default FIFO word width
package fifo_drain_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } state_e;

    localparam int DRAIN_CNT_WIDTH    = 16;
    localparam int DEFAULT_DATA_WIDTH = 8;

endpackage : fifo_drain_pkg

// File: rtl/fifo_rd_drain_if.sv
// fifo_rd_drain_if: FIFO read port plus downstream valid/ready handshake.
//   empty      FIFO empty flag (registered in the FIFO read logic)
//   rdata      FIFO read data at the current read address
//   rinc       pop strobe towards the FIFO, one cycle per word
//   out_data   word presented downstream
//   out_valid  out_data holds an undelivered word
//   out_ready  downstream accepts out_data this cycle
// Modports:
//   master  the drain (drives rinc and the output side)
//   slave   FIFO read logic plus downstream consumer
interface fifo_rd_drain_if
    import fifo_drain_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

    logic                  empty;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rinc;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        input  empty,
        input  rdata,
        output rinc,
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        output empty,
        output rdata,
        input  rinc,
        input  out_data,
        input  out_valid,
        output out_ready
    );

endinterface : fifo_rd_drain_if

// File: rtl/fifo_rd_drain.sv
// fifo_rd_drain: read-side consumer of the async FIFO (FIFO read clock domain).
// Pops one word per rinc pulse into an output register and hands it downstream
// over valid/ready. After each pop the FSM spends one SETTLE cycle so that the
// FIFO's registered empty flag has caught up before the next pop decision.
//
//   state  | meaning
//   IDLE   | may pop when FIFO not empty and the output register is free/leaving
//   SETTLE | one cycle after a pop; empty may be stale, never pop
//
// Ports:
//   CLK        FIFO read-domain clock, rising edge
//   RST        synchronous reset, active-high
//   bus        fifo_rd_drain_if.master (FIFO read port + downstream handshake)
//   drain_cnt  completed transfer count, wraps (only with FIFO_DRAIN_CNT_EN)
//
// Build option: define FIFO_DRAIN_CNT_EN to add the drain_cnt port and counter.
module fifo_rd_drain
    import fifo_drain_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                       CLK,
    input  logic                       RST,
    fifo_rd_drain_if.master            bus
`ifdef FIFO_DRAIN_CNT_EN
    ,
    output logic [DRAIN_CNT_WIDTH-1:0] drain_cnt
`endif
);

    state_e                state_q, state_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  pop;
    logic                  xfer;

    assign xfer = out_valid_q & bus.out_ready;

    // The output register may be refilled in the same cycle it is delivered,
    // which keeps the downstream side free of bubbles.
    assign pop = (state_q == IDLE) & ~bus.empty & (~out_valid_q | bus.out_ready);

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (pop) begin
            out_valid_d = 1'b1;
            out_data_d  = bus.rdata;
        end else if (xfer) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // The FIFO is reset in the same cycle; a pop during reset would skew its pointers.
    assign bus.rinc      = pop & ~RST;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

`ifdef FIFO_DRAIN_CNT_EN
    logic [DRAIN_CNT_WIDTH-1:0] drain_cnt_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            drain_cnt_q <= '0;
        end else if (xfer) begin
            drain_cnt_q <= drain_cnt_q + 1'b1;
        end
    end

    assign drain_cnt = drain_cnt_q;
`endif

endmodule : fifo_rd_drain
